// File: rtl/shared_memory_ctrl.sv
// Shared byte-wide memory arbitrated between several cores.
// One request is served at a time: IDLE picks a round-robin winner and latches
// its operation, ACC performs the read or write, RESP closes the completion pulse.
module shared_memory_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req_ld,
  input  logic [NUM_CORES-1:0]        mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_shared_memory,
  input  logic [NUM_CORES*DATA_W-1:0] mem_dat_st,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]           mem_dat,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_id
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   isLoad_q, isLoad_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      memDat_q, memDat_d;
  logic [NUM_CORES-1:0]   valData_q, valData_d;
  logic [NUM_CORES-1:0]   servedMask_q, servedMask_d;

  logic [DATA_W-1:0]      memArray_q [DEPTH];

  logic [NUM_CORES-1:0]   eligible;
  logic                   anyEligible;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       nextPtr;
  logic                   memWrite;

  // The core whose completion pulse just ended sits out one IDLE sample, so a
  // core that keeps its request level high cannot be re-granted before it has
  // had a cycle to react to val_data.
  assign eligible = (mem_req_ld | mem_req_st) & ~servedMask_q;

  // Round-robin search: walk the cores starting at the pointer and take the
  // first eligible one.
  always_comb begin
    winner      = '0;
    anyEligible = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = IDX_W'((int'(rrPtr_q) + i) % NUM_CORES);
      if (!anyEligible && eligible[cand]) begin
        anyEligible = 1'b1;
        winner      = cand;
      end
    end
  end

  assign nextPtr = (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + IDX_W'(1);

  // Next-state and datapath decisions for the three-state service loop.
  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    grant_d      = grant_q;
    isLoad_d     = isLoad_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    memDat_d     = memDat_q;
    valData_d    = '0;
    servedMask_d = '0;
    case (state_q)
      IDLE: begin
        if (anyEligible) begin
          state_d  = ACC;
          grant_d  = winner;
          rrPtr_d  = nextPtr;
          // A load wins over a simultaneous store from the same core.
          isLoad_d = mem_req_ld[winner];
          for (int k = 0; k < NUM_CORES; k++) begin
            if (winner == IDX_W'(k)) begin
              addr_d  = addr_shared_memory[k*ADDR_W +: ADDR_W];
              wdata_d = mem_dat_st[k*DATA_W +: DATA_W];
            end
          end
        end
      end
      ACC: begin
        if (isLoad_q) begin
          memDat_d = memArray_q[addr_q];
        end
        valData_d[grant_q] = 1'b1;
        state_d            = RESP;
      end
      RESP: begin
        servedMask_d[grant_q] = 1'b1;
        state_d               = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      grant_q      <= '0;
      isLoad_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      memDat_q     <= '0;
      valData_q    <= '0;
      servedMask_q <= '0;
    end else begin
      state_q      <= state_d;
      rrPtr_q      <= rrPtr_d;
      grant_q      <= grant_d;
      isLoad_q     <= isLoad_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      memDat_q     <= memDat_d;
      valData_q    <= valData_d;
      servedMask_q <= servedMask_d;
    end
  end

  // A store is suppressed if reset is high at the write edge, so an aborted
  // transaction never leaves partial effects in memory.
  assign memWrite = (state_q == ACC) && !isLoad_q && !reset;

  // Memory storage is deliberately outside the reset domain so contents
  // survive a reset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      memArray_q[addr_q] <= wdata_q;
    end
  end

  assign val_data = valData_q;
  assign mem_dat  = memDat_q;
  assign grant_id = grant_q;
  // Busy covers the whole service loop and also the IDLE cycle in which a
  // grant is about to be taken, so back-to-back requests see no gap.
  assign busy     = !reset && ((state_q != IDLE) || anyEligible);

endmodule

// File: tb/tb_shared_memory_ctrl.sv
// Scoreboard bench for shared_memory_ctrl: directed requests push expected
// completions into a queue; a monitor pops one entry per val_data pulse.
module tb_shared_memory_ctrl;

  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    mem_req_ld;
  logic [NC-1:0]    mem_req_st;
  logic [NC*AW-1:0] addr_shared_memory;
  logic [NC*DW-1:0] mem_dat_st;
  logic [NC-1:0]    val_data;
  logic [DW-1:0]    mem_dat;
  logic             busy;
  logic [1:0]       grant_id;

  typedef struct {
    int            core;
    bit            isLoad;
    logic [DW-1:0] data;
    int            expCycle;
    string         name;
  } expT;

  expT sb[$];

  int vectorsApplied = 0;
  int miscompares    = 0;
  int cycle          = 0;

  shared_memory_ctrl #(
    .NUM_CORES(NC),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req_ld(mem_req_ld),
    .mem_req_st(mem_req_st),
    .addr_shared_memory(addr_shared_memory),
    .mem_dat_st(mem_dat_st),
    .val_data(val_data),
    .mem_dat(mem_dat),
    .busy(busy),
    .grant_id(grant_id)
  );

  // Free-running clock and cycle counter used for latency expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectPulse(input int core, input bit isLoad, input logic [DW-1:0] data,
                             input int expCycle, input string name);
    expT e;
    e.core     = core;
    e.isLoad   = isLoad;
    e.data     = data;
    e.expCycle = expCycle;
    e.name     = name;
    sb.push_back(e);
  endtask

  // Raise a level request for one core and hold it until its val_data is seen.
  task automatic applyStimulus(input int core, input bit ld, input bit st,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input string name);
    bit seen;
    seen = 1'b0;
    addr_shared_memory[core*AW +: AW] = addr;
    mem_dat_st[core*DW +: DW]         = data;
    mem_req_ld[core]                  = ld;
    mem_req_st[core]                  = st;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (val_data[core]) seen = 1'b1;
    end
    mem_req_ld[core] = 1'b0;
    mem_req_st[core] = 1'b0;
    if (!seen) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL %s timeout: no val_data[%0d] within 60 cycles", name, core);
    end
  endtask

  task automatic idleGap();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest expected completion.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (val_data !== '0) begin
        if (sb.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL unexpected pulse: val_data=0x%0h with empty scoreboard", val_data);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, " val_data"}, 32'(val_data), 32'(1) << e.core);
          if (e.expCycle >= 0)
            checkOutput({e.name, " latency cycle"}, 32'(cycle), 32'(e.expCycle));
          checkOutput({e.name, " mem_dat"}, 32'(mem_dat), 32'(e.data));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int busyLow;
    reset              = 1'b1;
    mem_req_ld         = '0;
    mem_req_st         = '0;
    addr_shared_memory = '0;
    mem_dat_st         = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst val_data", 32'(val_data), 32'h0);
    checkOutput("rst mem_dat", 32'(mem_dat), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst grant_id", 32'(grant_id), 32'h0);
    reset = 1'b0;

    // Seed 0x000, then load+store together: load wins, memory untouched.
    idleGap();
    expectPulse(0, 1'b0, 8'h00, cycle + 2, "st0 0x000");
    applyStimulus(0, 1'b0, 1'b1, 12'h000, 8'h11, "st0 0x000");
    idleGap();
    expectPulse(0, 1'b1, 8'h11, cycle + 2, "ldst0 0x000");
    applyStimulus(0, 1'b1, 1'b1, 12'h000, 8'h22, "ldst0 0x000");
    idleGap();
    expectPulse(0, 1'b1, 8'h11, cycle + 2, "ld0 0x000 recheck");
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 8'h00, "ld0 0x000 recheck");

    // Store/load pair on core 1 at 0x3F0.
    idleGap();
    expectPulse(1, 1'b0, 8'h11, cycle + 2, "st1 0x3F0");
    applyStimulus(1, 1'b0, 1'b1, 12'h3F0, 8'hA5, "st1 0x3F0");
    idleGap();
    expectPulse(1, 1'b1, 8'hA5, cycle + 2, "ld1 0x3F0");
    applyStimulus(1, 1'b1, 1'b0, 12'h3F0, 8'h00, "ld1 0x3F0");

    // Top address.
    idleGap();
    expectPulse(1, 1'b0, 8'hA5, cycle + 2, "st1 0xFFF");
    applyStimulus(1, 1'b0, 1'b1, 12'hFFF, 8'h5A, "st1 0xFFF");
    idleGap();
    expectPulse(1, 1'b1, 8'h5A, cycle + 2, "ld1 0xFFF");
    applyStimulus(1, 1'b1, 1'b0, 12'hFFF, 8'h00, "ld1 0xFFF");

    // Reset again (memory must survive), then all four cores load at once.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst2 mem_dat", 32'(mem_dat), 32'h0);
    checkOutput("rst2 grant_id", 32'(grant_id), 32'h0);
    reset = 1'b0;
    idleGap();
    expectPulse(0, 1'b1, 8'h11, -1, "burst core0");
    expectPulse(1, 1'b1, 8'hA5, -1, "burst core1");
    expectPulse(2, 1'b1, 8'h5A, -1, "burst core2");
    expectPulse(3, 1'b1, 8'h11, -1, "burst core3");
    busyLow = 0;
    fork
      applyStimulus(0, 1'b1, 1'b0, 12'h000, 8'h00, "burst core0");
      applyStimulus(1, 1'b1, 1'b0, 12'h3F0, 8'h00, "burst core1");
      applyStimulus(2, 1'b1, 1'b0, 12'hFFF, 8'h00, "burst core2");
      applyStimulus(3, 1'b1, 1'b0, 12'h000, 8'h00, "burst core3");
      begin
        for (int i = 0; i < 12; i++) begin
          #1;
          if (!busy) busyLow++;
          @(negedge clk);
        end
      end
    join
    checkOutput("burst busy low samples", 32'(busyLow), 32'h0);
    checkOutput("burst last grant_id", 32'(grant_id), 32'h3);

    // Core 2 requests continuously while core 3 asks once: core 3 gets the
    // second grant and the pointer wraps back to core 2.
    idleGap();
    expectPulse(2, 1'b1, 8'h5A, -1, "fair core2 #1");
    expectPulse(3, 1'b1, 8'hA5, -1, "fair core3");
    expectPulse(2, 1'b1, 8'h5A, -1, "fair core2 #2");
    expectPulse(2, 1'b1, 8'h5A, -1, "fair core2 #3");
    fork
      begin
        for (int j = 0; j < 3; j++)
          applyStimulus(2, 1'b1, 1'b0, 12'hFFF, 8'h00, "fair core2");
      end
      applyStimulus(3, 1'b1, 1'b0, 12'h3F0, 8'h00, "fair core3");
    join
    checkOutput("fair last grant_id", 32'(grant_id), 32'h2);

    // Reset during ACC of a store; a short-lived core 3 request is dropped.
    idleGap();
    expectPulse(1, 1'b0, 8'h00, -1, "st1 0xFFF after abort");
    fork
      applyStimulus(1, 1'b0, 1'b1, 12'hFFF, 8'h77, "st1 0xFFF after abort");
      begin
        @(negedge clk);
        checkOutput("abort busy in ACC", 32'(busy), 32'h1);
        addr_shared_memory[3*AW +: AW] = 12'h3F0;
        mem_req_ld[3] = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("abort val_data", 32'(val_data), 32'h0);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort grant_id", 32'(grant_id), 32'h0);
        checkOutput("abort mem_dat", 32'(mem_dat), 32'h0);
        @(negedge clk);
        checkOutput("abort val_data hold", 32'(val_data), 32'h0);
        mem_req_ld[3] = 1'b0;
        reset = 1'b0;
      end
    join
    idleGap();
    expectPulse(1, 1'b1, 8'h77, cycle + 2, "ld1 0xFFF after abort");
    applyStimulus(1, 1'b1, 1'b0, 12'hFFF, 8'h00, "ld1 0xFFF after abort");
    checkOutput("final grant_id", 32'(grant_id), 32'h1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_memory_ctrl.md
SHARED_MEMORY_CTRL -- requirements
Module: shared_memory_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4, number of core request ports.
REQ-002 Parameter ADDR_W, default 12, byte address width; memory depth SHALL be 2**ADDR_W bytes.
REQ-003 Parameter DATA_W, default 8, data width.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_req_ld  input  NUM_CORES  per-core load request; level, held until val_data seen.
REQ-007 mem_req_st  input  NUM_CORES  per-core store request; level, held until val_data seen.
REQ-008 addr_shared_memory  input  NUM_CORES*ADDR_W  per-core address; core k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 mem_dat_st  input  NUM_CORES*DATA_W  per-core store data; core k occupies bits [k*DATA_W +: DATA_W].
REQ-010 val_data  output  NUM_CORES  per-core one-cycle completion pulse, for loads and stores.
REQ-011 mem_dat  output  DATA_W  load data, broadcast to all cores, qualified by val_data.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 grant_id  output  clog2(NUM_CORES)  index of the core currently or last served.

Function
REQ-014 FSM states IDLE, ACC, RESP; each transition SHALL occur on one posedge.
REQ-015 IDLE: if any core has mem_req_ld or mem_req_st high, select a winner, latch its index, op, address and store data; go to ACC. Otherwise stay in IDLE.
REQ-016 Arbitration: round-robin; search starts at pointer rr_ptr, which resets to 0; after granting core k, rr_ptr SHALL become (k+1) mod NUM_CORES.
REQ-017 If one core asserts ld and st together, the load SHALL be served and the store ignored for that grant.
REQ-018 ACC, load: the latched address SHALL be read and the byte registered onto mem_dat.
REQ-019 ACC, store: the latched data SHALL be written to the latched address; mem_dat SHALL hold its previous value.
REQ-020 ACC SHALL set val_data[winner] high and go to RESP; all other val_data bits SHALL stay low.
REQ-021 RESP: val_data SHALL be cleared on the next posedge and the FSM SHALL return to IDLE; val_data width is exactly one cycle.
REQ-022 Latency: a request present before edge E0 in IDLE SHALL produce val_data high during the cycle after E1. The next grant SHALL be sampled no earlier than E3.
REQ-023 A core whose val_data was high in the previous cycle SHALL NOT be eligible for grant at the current IDLE sample.
REQ-024 Requests arriving while busy SHALL wait and SHALL NOT be dropped; service is one request at a time.
REQ-025 Addresses SHALL be used modulo 2**ADDR_W with no wrap error; all DATA_W-bit values are stored unmodified.
REQ-026 A load that follows a store to the same address SHALL return the newly stored byte.
REQ-027 Requests that drop before grant SHALL be ignored, with no val_data pulse.

Reset
REQ-028 While reset is high: state=IDLE, rr_ptr=0, val_data=0, mem_dat=0, busy=0, grant_id=0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A store in ACC SHALL NOT be written if reset is high at that edge.
REQ-031 Reset asserted mid-transaction SHALL abort it, with no val_data pulse; after release, still-held requests SHALL be served anew.

Verification
REQ-032 Core 1 stores 0xA5 to 0x3F0, then core 1 loads 0x3F0 -> two val_data[1] pulses; second has mem_dat=0xA5; each pulse appears 2 cycles after its request.
REQ-033 Cores 0,1,2,3 request loads in the same cycle after reset -> grants in order 0,1,2,3; exactly one val_data bit high per pulse; busy never low between grants while requests remain.
REQ-034 Core 2 holds continuous requests while core 3 requests once -> core 3 is served within NUM_CORES grants (no starvation); rr_ptr wraps 3->0.
REQ-035 Core 0 asserts ld and st together at address 0x000, where memory holds 0x11 and store data is 0x22 -> load served, mem_dat=0x11, memory still 0x11.
REQ-036 Reset pulsed during ACC of a store of 0x77 to 0xFFF -> no val_data, 0xFFF unchanged; after release the held request completes and a load of 0xFFF returns 0x77.
REQ-037 Core 1 stores 0x5A to address 0xFFF, then loads 0xFFF -> mem_dat=0x5A, with no spurious pulses on other cores.
